// File: rtl/button_scan_ctrl_if.sv
// Purpose: groups the button input and the debounced/event outputs of button_scan_ctrl.
// Ports: btn_i (raw levels), level_o, press_o, release_o, repeat_o (per-button), busy_o.
// master = controller side (drives events), slave = consumer side (drives raw buttons).
interface button_scan_ctrl_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] repeat_o;
  logic             busy_o;

  modport master (
    input  btn_i,
    output level_o, press_o, release_o, repeat_o, busy_o
  );

  modport slave (
    output btn_i,
    input  level_o, press_o, release_o, repeat_o, busy_o
  );
endinterface

// File: rtl/button_scan_ctrl.sv
// Purpose: time-multiplexed debouncer for N_BTN buttons with press/release/auto-repeat pulses.
// Latency: each button is visited once per SAMPLE_DIV clocks; event pulses are registered, 1 clock wide.
// Ports: clk, reset (sync, active-high), bus (master modport: btn_i in; level/press/release/repeat/busy out).
module button_scan_ctrl #(
  parameter int N_BTN        = 4,
  parameter int HIST_LEN     = 8,
  parameter int SAMPLE_DIV   = 1024,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                clk,
  input  logic                reset,
  button_scan_ctrl_if.master  bus
);

  localparam int CNT_W   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IDX_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  // Two-flop synchronizer; btn_s_q is the synchronized button vector.
  logic [N_BTN-1:0]    sync1_q;
  logic [N_BTN-1:0]    btn_s_q;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HIST_LEN-1:0] hist_q [N_BTN];
  logic [HIST_LEN-1:0] hist_d [N_BTN];
  logic [REP_W-1:0]    rep_q  [N_BTN];
  logic [REP_W-1:0]    rep_d  [N_BTN];
  logic [N_BTN-1:0]    level_q, level_d;
  logic [N_BTN-1:0]    press_q, press_d;
  logic [N_BTN-1:0]    release_q, release_d;
  logic [N_BTN-1:0]    repeat_q, repeat_d;
  logic                busy_q;

  logic                tick;
  logic [HIST_LEN-1:0] h;

  assign tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  // History of the button being visited, including this visit's sample.
  assign h = {hist_q[idx_q][HIST_LEN-2:0], btn_s_q[idx_q]};

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    state_d   = state_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        hist_d[idx_q] = h;
        if (level_q[idx_q]) begin
          // Held button: a release can only happen here, and the repeat
          // countdown runs on every visit where the level was high.
          if (~|h) begin
            level_d[idx_q]   = 1'b0;
            release_d[idx_q] = 1'b1;
          end
          if (rep_q[idx_q] == REP_W'(1)) begin
            repeat_d[idx_q] = 1'b1;
            rep_d[idx_q]    = REP_W'(REPEAT_RATE);
          end else if (rep_q[idx_q] != '0) begin
            rep_d[idx_q] = rep_q[idx_q] - REP_W'(1);
          end
        end else if (&h) begin
          level_d[idx_q] = 1'b1;
          press_d[idx_q] = 1'b1;
          rep_d[idx_q]   = REP_W'(REPEAT_DELAY);
        end

        if (idx_q == IDX_W'(N_BTN - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      btn_s_q   <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= '0;
        rep_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= bus.btn_i;
      btn_s_q   <= sync1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      // Registered from the next state so busy tracks state_q exactly.
      busy_q    <= (state_d == SCAN);
      hist_q    <= hist_d;
      rep_q     <= rep_d;
    end
  end

  assign bus.level_o   = level_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
  assign bus.repeat_o  = repeat_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Bench for button_scan_ctrl with N_BTN=2, HIST_LEN=3, SAMPLE_DIV=8, REPEAT_DELAY=2, REPEAT_RATE=1.
// A reference model predicts scan timing from the clock count since reset and queues expected pulses;
// a negedge monitor compares level/busy every cycle and pops the queue whenever the DUT pulses.
module tb_button_scan_ctrl;

  localparam int NB  = 2;
  localparam int HL  = 3;
  localparam int SD  = 8;
  localparam int RD  = 2;
  localparam int RR  = 1;

  typedef struct {
    int           cyc;
    logic [NB-1:0] p;
    logic [NB-1:0] r;
    logic [NB-1:0] q;
  } ev_t;

  logic clk;
  logic reset;

  button_scan_ctrl_if #(.N_BTN(NB)) bus ();

  button_scan_ctrl #(
    .N_BTN(NB), .HIST_LEN(HL), .SAMPLE_DIV(SD),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  ev_t           evq[$];
  int            gcyc = 0;          // edges since time zero
  int            t    = 0;          // edges since reset released
  logic [NB-1:0] samp [0:8191];     // raw button value captured at each edge
  logic [NB-1:0] mlvl = '0;
  logic          mbusy = 1'b0;
  logic [HL-1:0] mh [NB];
  int            held [NB];

  initial begin
    for (int i = 0; i < NB; i++) begin
      mh[i]   = '0;
      held[i] = 0;
    end
  end

  always @(posedge clk) begin
    ev_t           e;
    logic [HL-1:0] nh;
    int            k;
    gcyc++;
    if (reset) begin
      t     = 0;
      mlvl  = '0;
      mbusy = 1'b0;
      for (int i = 0; i < NB; i++) begin
        mh[i]   = '0;
        held[i] = 0;
      end
    end else begin
      t++;
      if (t < 8192) samp[t] = bus.btn_i;
      // A scan starts SD edges after reset release and every SD edges after;
      // button k is visited on the (k+1)-th edge after the scan starts.
      if (t >= SD + 1 && (t % SD) >= 1 && (t % SD) <= NB) begin
        k     = (t % SD) - 1;
        e.cyc = gcyc;
        e.p   = '0;
        e.r   = '0;
        e.q   = '0;
        // The value seen on a visit is what the button showed two edges earlier.
        nh    = {mh[k][HL-2:0], samp[t-2][k]};
        mh[k] = nh;
        if (mlvl[k]) begin
          held[k]++;
          if (held[k] >= RD && ((held[k] - RD) % RR) == 0) e.q[k] = 1'b1;
          if (nh == '0) begin
            e.r[k]  = 1'b1;
            mlvl[k] = 1'b0;
          end
        end else if (nh == '1) begin
          e.p[k]  = 1'b1;
          mlvl[k] = 1'b1;
          held[k] = 0;
        end
        if ((e.p | e.r | e.q) != '0) evq.push_back(e);
      end
      mbusy = (t >= SD) && ((t % SD) < NB);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ev_t e;
    if (gcyc > 0) begin
      checks++;
      if (bus.level_o !== mlvl) begin
        errors++;
        $display("FAIL level cyc %0d: got %b want %b", gcyc, bus.level_o, mlvl);
      end
      checks++;
      if (bus.busy_o !== mbusy) begin
        errors++;
        $display("FAIL busy cyc %0d: got %b want %b", gcyc, bus.busy_o, mbusy);
      end
      if ((bus.press_o | bus.release_o | bus.repeat_o) !== '0) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc %0d: got p=%b r=%b q=%b want none",
                   gcyc, bus.press_o, bus.release_o, bus.repeat_o);
        end else begin
          e = evq.pop_front();
          if (e.cyc != gcyc || bus.press_o !== e.p || bus.release_o !== e.r ||
              bus.repeat_o !== e.q) begin
            errors++;
            $display("FAIL pulse cyc %0d: got p=%b r=%b q=%b want cyc %0d p=%b r=%b q=%b",
                     gcyc, bus.press_o, bus.release_o, bus.repeat_o, e.cyc, e.p, e.r, e.q);
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc <= gcyc) begin
        checks++;
        errors++;
        e = evq.pop_front();
        $display("FAIL missing_pulse cyc %0d: got none want p=%b r=%b q=%b",
                 gcyc, e.p, e.r, e.q);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [NB-1:0] v, input int n);
    bus.btn_i = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int waited;
    bus.btn_i = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single button held: press on 3rd visit, then auto-repeat, then release.
    hold(2'b01, 64);
    hold(2'b00, 40);

    // Alternate-scan toggling never gathers three agreeing samples.
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 2'b01 : 2'b00, SD);
    hold(2'b00, 24);

    // Both buttons together, then reset during a scan with both levels high.
    hold(2'b11, 48);
    waited = 0;
    while (bus.busy_o !== 1'b1 && waited < 4 * SD) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait: got busy=%b want 1 within %0d cycles", bus.busy_o, 4 * SD);
    end
    pulse_reset();
    hold(2'b11, 48);
    hold(2'b00, 40);

    // Randomized levels with occasional resets.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 14) == 0) pulse_reset();
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 30));
    end
    hold(2'b00, 60);

    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending want 0", evq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/button_scan_ctrl.md
BUTTON_SCAN_CTRL -- requirements
Module: button_scan_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of buttons scanned; legal range 1..16.
REQ-002 Parameter HIST_LEN, default 8: samples of agreement needed to change a debounced level; legal range 2..16.
REQ-003 Parameter SAMPLE_DIV, default 1024: clocks between scan starts; SHALL be > N_BTN + 1.
REQ-004 Parameter REPEAT_DELAY, default 32: scan visits of continuous hold before the first repeat; legal range >= 1.
REQ-005 Parameter REPEAT_RATE, default 8: scan visits between later repeats; legal range >= 1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 btn  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-009 level  output  N_BTN  debounced level per button.
REQ-010 press  output  N_BTN  one-clock pulse on a 0->1 debounced transition.
REQ-011 release  output  N_BTN  one-clock pulse on a 1->0 debounced transition.
REQ-012 repeat  output  N_BTN  one-clock auto-repeat pulse while held.
REQ-013 busy  output  1  high while the state machine is in SCAN.

Function
REQ-014 Each btn bit SHALL pass through a 2-flop synchronizer before any use; sync output is btn_s.
REQ-015 Prescaler cnt SHALL count 0..SAMPLE_DIV-1 and wrap; tick = (cnt == SAMPLE_DIV-1).
REQ-016 FSM states SHALL be IDLE and SCAN; IDLE->SCAN on tick with idx <= 0; SCAN->IDLE in the cycle processing idx == N_BTN-1.
REQ-017 In SCAN, exactly one button idx SHALL be visited per clock; idx increments by 1 each cycle.
REQ-018 A visit SHALL update hist[idx] <= {hist[idx][HIST_LEN-2:0], btn_s[idx]}; the decision uses the new history value h.
REQ-019 If h is all ones and level[idx]=0: level[idx] <= 1, press[idx] <= 1, rep[idx] <= REPEAT_DELAY.
REQ-020 If h is all zeros and level[idx]=1: level[idx] <= 0 and release[idx] <= 1.
REQ-021 Mixed h SHALL leave level[idx] unchanged.
REQ-022 If level[idx]=1 and no press occurs this visit: rep[idx] decrements; when rep[idx]==1 before the visit, repeat[idx] <= 1 and rep[idx] <= REPEAT_RATE.
REQ-023 rep[idx] SHALL be wide enough for max(REPEAT_DELAY, REPEAT_RATE) and SHALL never underflow.
REQ-024 press, release and repeat SHALL be registered and high for exactly one clock; all other bits are 0 in that cycle and otherwise.
REQ-025 Unvisited buttons SHALL keep hist, level and rep unchanged.
REQ-026 A tick arriving while in SCAN is impossible by REQ-003; no queuing is required.
REQ-027 busy SHALL be registered and equal (state == SCAN).

Reset
REQ-028 While reset=1: cnt=0, state IDLE, idx=0, sync flops=0, hist=0, rep=0, level=0, press=0, release=0, repeat=0, busy=0.
REQ-029 Reset asserted mid-SCAN SHALL abort the scan; no pulse is emitted in the following cycle.
REQ-030 After reset deasserts, the first tick SHALL occur SAMPLE_DIV clocks later.

Verification (N_BTN=2, HIST_LEN=3, SAMPLE_DIV=8, REPEAT_DELAY=2, REPEAT_RATE=1)
REQ-031 Hold btn=2'b01 from reset release -> level[0] rises on the 3rd visit; press[0] is one clock high; level[1] stays 0; release stays 0.
REQ-032 btn[0] toggling 1,0,1 on alternate scans -> level[0] stays 0; press[0] is never asserted.
REQ-033 Hold btn[0] after press -> repeat[0] pulses on visits 2, 3, 4, ... after the press visit; release btn[0] -> release[0] pulses after 3 zero visits and repeats stop.
REQ-034 Both buttons pressed together -> press[0] and press[1] occur in consecutive clocks of the same scan.
REQ-035 Assert reset for 1 clock while busy=1 with level=2'b11 -> all outputs 0 next clock; no release pulse; rescan starts 8 clocks later.
REQ-036 Check busy: it is high for exactly N_BTN=2 clocks per SAMPLE_DIV=8 clocks.
